seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the multiplexed 7-segment display bus. Samples the
//  active-low anode select and active-low segment lines, waits for each
//  digit slot to settle, and decodes the glyph back to a 4-bit hex value.
//  Rebuilds a 4-digit frame for lock-state readback and self-check logic.
//  Segment encoding: seg[6]=a ... seg[0]=g, 0 = segment lit.
// PARAMETERS
//  SETTLE_CYCLES  4   consecutive clk cycles an/seg must be unchanged before capture (>=1)
//  CNT_W          8   width of settle counter; must hold SETTLE_CYCLES
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  an           in   4   anode select, active low; an[i]=0 selects digit i
//  seg          in   7   segment lines, active low, {a,b,c,d,e,f,g}
//  digits       out  16  decoded digits; digit i in [4i+3:4i]
//  dig_valid    out  4   bit i set once digit i captured since last frame
//  dig_err      out  4   bit i set if last capture of digit i was not a hex glyph
//  dig_blank    out  4   bit i set if last capture of digit i was 7'b1111111
//  frame_strobe out  1   one-cycle pulse when all 4 digits captured in a frame
// BEHAVIOUR
//  Reset (async, rst=1): digits=16'h0, dig_valid=0, dig_err=0, dig_blank=0,
//   frame_strobe=0, FSM=IDLE, settle counter=0, sample registers=an 4'hF/seg 7'h7F.
//  Inputs registered once (an_q, seg_q) before use; all timing counted on an_q/seg_q.
//  FSM states:
//   IDLE    : an_q not one-hot-low (none or >1 low). Counter held 0.
//             -> SETTLE when an_q has exactly one bit low.
//   SETTLE  : counter +1 per cycle while an_q/seg_q equal previous cycle.
//             Any change in an_q or seg_q: counter=0, stay SETTLE (or IDLE if
//             an_q no longer one-hot-low). Counter reaches SETTLE_CYCLES -> CAPTURE.
//   CAPTURE : single cycle. Write slot i (selected anode): digits nibble,
//             dig_err[i], dig_blank[i]; set dig_valid[i]. -> HOLD.
//   HOLD    : no further capture of same slot. Any change in an_q -> SETTLE or
//             IDLE per one-hot test; seg_q change with same an_q -> SETTLE
//             (re-capture of the same slot allowed, overwrites).
//  Decode table (seg -> nibble): 0000001->0 1001111->1 0010010->2 0000110->3
//   1001100->4 0100100->5 0100000->6 0001111->7 0000000->8 0000100->9
//   0001000->A 1100000->B 0110001->C 1000010->D 0110000->E 0111000->F.
//  1111111: nibble=0, dig_blank=1, dig_err=0. Any other pattern: nibble=0, dig_err=1.
//  Latency: capture registered outputs update SETTLE_CYCLES+2 clk after an/seg
//   become stable at the pins (1 input reg + settle + capture).
//  Frame: when dig_valid becomes 4'hF (set in the CAPTURE cycle), frame_strobe=1 for
//   the following cycle and dig_valid clears to 0 in that same cycle; digits,
//   dig_err, dig_blank retain values. Capture of a new slot in the strobe cycle
//   sets its dig_valid bit (set wins over clear).
//  Counter saturates at SETTLE_CYCLES; never wraps.
//  rst mid-SETTLE/CAPTURE: everything returns to reset values immediately;
//   no partial write to digits.
// TESTING
//  1 Reset: assert rst with inputs toggling -> all outputs 0, no strobe for 10 cycles.
//  2 Scan an=1110,1101,1011,0111 with seg 0010010/1001100/0001000/0111000, 8 cycles each
//    -> digits=16'hFA42, dig_err=0, frame_strobe pulses once after 4th slot, dig_valid->0.
//  3 Glitch: an=1110, seg alternates each cycle for 3 cycles then holds 0000001 ->
//    capture only SETTLE_CYCLES+2 cycles after hold begins; digits[3:0]=0, no err.
//  4 seg=1111111 on slot 2 -> dig_blank[2]=1, dig_err[2]=0; seg=1010101 -> dig_err[2]=1.
//  5 an=1100 (two low) or 1111 for 20 cycles -> no capture, dig_valid unchanged.
//  6 rst pulse in SETTLE cycle 2 of slot 1 -> no capture; clean scan after completes frame.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus.
// Waits for each digit slot to settle, decodes the glyph, rebuilds a 4-digit frame.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic [3:0]  dig_err,
    output logic [3:0]  dig_blank,
    output logic        frame_strobe
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

    logic [3:0]       an_q, an_p;
    logic [6:0]       seg_q, seg_p;
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       sel;
    logic             onehot;
    logic             changed;
    logic             cap;
    logic [3:0]       nib;
    logic             glyph_err;
    logic             glyph_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            an_p  <= 4'hF;
            seg_p <= 7'h7F;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_p  <= an_q;
            seg_p <= seg_q;
        end
    end

    assign sel     = ~an_q;
    assign onehot  = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
    assign changed = (an_q != an_p) || (seg_q != seg_p);
    assign cnt_inc = (cnt >= SETTLE_MAX) ? SETTLE_MAX : cnt + CNT_W'(1);

    // The capture write lands on the same edge that enters CAPTURE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (onehot) state_n = SETTLE;
            end
            SETTLE: begin
                if (changed || !onehot) begin
                    cnt_n   = '0;
                    state_n = onehot ? SETTLE : IDLE;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == SETTLE_MAX) begin
                        state_n = CAPTURE;
                        cap     = 1'b1;
                    end
                end
            end
            default: begin
                if (changed) begin
                    cnt_n   = '0;
                    state_n = onehot ? SETTLE : IDLE;
                end else begin
                    state_n = HOLD;
                end
            end
        endcase
    end

    always_comb begin
        nib         = 4'h0;
        glyph_err   = 1'b0;
        glyph_blank = 1'b0;
        case (seg_q)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            7'b1111111: glyph_blank = 1'b1;
            default:    glyph_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A completed frame clears dig_valid, but a fresh capture still sets its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits       <= 16'h0;
            dig_valid    <= 4'h0;
            dig_err      <= 4'h0;
            dig_blank    <= 4'h0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= (dig_valid == 4'hF);
            dig_valid    <= ((dig_valid == 4'hF) ? 4'h0 : dig_valid)
                          | (cap ? sel : 4'h0);
            for (int i = 0; i < 4; i++) begin
                if (cap && sel[i]) begin
                    digits[4*i +: 4] <= nib;
                    dig_err[i]       <= glyph_err;
                    dig_blank[i]     <= glyph_blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: decode table, frame assembly,
// glitch rejection, invalid anode patterns and reset mid-settle.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic [3:0]  dig_err;
    logic [3:0]  dig_blank;
    logic        frame_strobe;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int s0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       err;
        logic       blank;
    } vec_t;

    vec_t tbl[19];

    seg_scan_decoder #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .an(an),
        .seg(seg),
        .digits(digits),
        .dig_valid(dig_valid),
        .dig_err(dig_err),
        .dig_blank(dig_blank),
        .frame_strobe(frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_strobe === 1'b1) strobes++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slot(input logic [3:0] a, input logic [6:0] s,
                        input int n);
        an  = a;
        seg = s;
        tick(n);
    endtask

    initial begin
        tbl[0]  = '{7'b1111111, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{7'b1010101, 4'h0, 1'b1, 1'b0};
        tbl[2]  = '{7'b1111110, 4'h0, 1'b1, 1'b0};
        tbl[3]  = '{7'b0000001, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{7'b1001111, 4'h1, 1'b0, 1'b0};
        tbl[5]  = '{7'b0010010, 4'h2, 1'b0, 1'b0};
        tbl[6]  = '{7'b0000110, 4'h3, 1'b0, 1'b0};
        tbl[7]  = '{7'b1001100, 4'h4, 1'b0, 1'b0};
        tbl[8]  = '{7'b0100100, 4'h5, 1'b0, 1'b0};
        tbl[9]  = '{7'b0100000, 4'h6, 1'b0, 1'b0};
        tbl[10] = '{7'b0001111, 4'h7, 1'b0, 1'b0};
        tbl[11] = '{7'b0000000, 4'h8, 1'b0, 1'b0};
        tbl[12] = '{7'b0000100, 4'h9, 1'b0, 1'b0};
        tbl[13] = '{7'b0001000, 4'hA, 1'b0, 1'b0};
        tbl[14] = '{7'b1100000, 4'hB, 1'b0, 1'b0};
        tbl[15] = '{7'b0110001, 4'hC, 1'b0, 1'b0};
        tbl[16] = '{7'b1000010, 4'hD, 1'b0, 1'b0};
        tbl[17] = '{7'b0110000, 4'hE, 1'b0, 1'b0};
        tbl[18] = '{7'b0111000, 4'hF, 1'b0, 1'b0};

        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;

        // Reset held while inputs toggle
        s0 = strobes;
        for (int i = 0; i < 10; i++) begin
            an  = 4'($urandom);
            seg = 7'($urandom);
            tick(1);
            chk("reset_outputs",
                {3'b0, digits, dig_valid, dig_err, dig_blank, frame_strobe},
                32'h0);
        end
        chk("reset_no_strobe", strobes - s0, 0);
        an  = 4'hF;
        seg = 7'h7F;
        tick(1);
        rst = 1'b0;
        tick(2);

        // Four-slot scan building FA42
        s0 = strobes;
        slot(4'b1110, 7'b0010010, 8);
        slot(4'b1101, 7'b1001100, 8);
        slot(4'b1011, 7'b0001000, 8);
        slot(4'b0111, 7'b0111000, 6);
        chk("scan_valid_full", dig_valid, 4'hF);
        chk("scan_strobe_early", frame_strobe, 1'b0);
        tick(1);
        chk("scan_strobe", frame_strobe, 1'b1);
        chk("scan_valid_clr", dig_valid, 4'h0);
        chk("scan_digits", digits, 16'hFA42);
        chk("scan_err", dig_err, 4'h0);
        tick(1);
        chk("scan_strobe_end", frame_strobe, 1'b0);
        slot(4'hF, 7'h7F, 8);
        chk("scan_strobe_count", strobes - s0, 1);

        // Glitching segments on slot 0, then a stable 0
        an = 4'b1110;
        seg = 7'b1001111; tick(1);
        seg = 7'b0010010; tick(1);
        seg = 7'b1001111; tick(1);
        seg = 7'b0000001;
        tick(5);
        chk("glitch_no_early_cap", dig_valid[0], 1'b0);
        chk("glitch_digit_old", digits[3:0], 4'h2);
        tick(1);
        chk("glitch_cap", dig_valid[0], 1'b1);
        chk("glitch_digit", {dig_err[0], digits[3:0]}, 5'h00);

        // Decode table on slot 1
        an = 4'b1101;
        for (int i = 0; i < 19; i++) begin
            seg = tbl[i].seg;
            tick(8);
            chk($sformatf("decode_%0d", i),
                {digits[7:4], dig_err[1], dig_blank[1]},
                {tbl[i].nib, tbl[i].err, tbl[i].blank});
        end

        // Blank then invalid glyph on slot 2
        slot(4'b1011, 7'b1111111, 8);
        chk("blank_slot2", {digits[11:8], dig_err[2], dig_blank[2]},
            {4'h0, 1'b0, 1'b1});
        slot(4'b1011, 7'b1010101, 8);
        chk("err_slot2", {digits[11:8], dig_err[2], dig_blank[2]},
            {4'h0, 1'b1, 1'b0});
        chk("partial_valid", dig_valid, 4'b0111);

        // Illegal anode patterns never capture
        slot(4'b1100, 7'b0000000, 20);
        chk("two_low_valid", dig_valid, 4'b0111);
        chk("two_low_digits", digits, 16'hF0F0);
        slot(4'b1111, 7'b0000000, 20);
        chk("none_low_valid", dig_valid, 4'b0111);
        chk("none_low_flags", {dig_err, dig_blank}, 8'h40);

        // Reset during settle of slot 1
        slot(4'b1101, 7'b1001111, 3);
        rst = 1'b1;
        #1;
        chk("rst_async",
            {3'b0, digits, dig_valid, dig_err, dig_blank, frame_strobe},
            32'h0);
        an  = 4'hF;
        seg = 7'h7F;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("rst_no_cap", {digits, dig_valid}, 20'h0);

        // Clean scan after reset: 7531
        s0 = strobes;
        slot(4'b1110, 7'b1001111, 8);
        slot(4'b1101, 7'b0000110, 8);
        slot(4'b1011, 7'b0100100, 8);
        slot(4'b0111, 7'b0001111, 7);
        chk("rescan_strobe", frame_strobe, 1'b1);
        chk("rescan_digits", digits, 16'h7531);
        chk("rescan_valid_clr", dig_valid, 4'h0);
        slot(4'hF, 7'h7F, 8);
        chk("rescan_strobe_count", strobes - s0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
